// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and byte-strobe merge for register_file_mp.
// The merge is used by both the storage write and the read bypass.
package rf_pkg;
  localparam int RF_DEPTH_DEF  = 16;
  localparam int RF_WIDTH_DEF  = 64;
  localparam int RF_NUM_RD_DEF = 2;
  localparam int RF_WIDTH_MAX  = 512;
  localparam int RF_STRB_MAX   = RF_WIDTH_MAX / 8;

  typedef logic [RF_WIDTH_MAX-1:0] rf_word_t;
  typedef logic [RF_STRB_MAX-1:0]  rf_strb_t;

  // Callers zero-extend to the max width and truncate the result.
  function automatic rf_word_t rf_strb_merge(
    input rf_word_t i_old,
    input rf_word_t i_new,
    input rf_strb_t i_strb
  );
    rf_word_t w_m;
    for (int b = 0; b < RF_STRB_MAX; b++) begin
      w_m[8*b +: 8] = i_strb[b] ? i_new[8*b +: 8]
                                : i_old[8*b +: 8];
    end
    return w_m;
  endfunction
endpackage

// File: rtl/register_file_mp_read_port.sv
// rf_read_port: one registered read port with write-first bypass.
// Out-of-range addresses return zero with the valid flag set.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH_DEF,
  parameter int WIDTH = RF_WIDTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_read_en,
  input  logic [AW-1:0]      i_raddr,
  input  logic [WIDTH-1:0]   i_mem [DEPTH],
  input  logic               i_wr_ok,
  input  logic [AW-1:0]      i_waddr,
  input  logic [WIDTH-1:0]   i_wdata,
  input  logic [WIDTH/8-1:0] i_wstrb,
  output logic [WIDTH-1:0]   o_rdata,
  output logic               o_rvalid
);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic             w_in_range;
  logic             w_hit;
  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_merged;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;

  assign w_in_range = {1'b0, i_raddr} < LP_DEPTH;
  assign w_old      = w_in_range ? i_mem[i_raddr] : '0;
  // i_wr_ok already excludes dropped writes, so a hit is in range
  assign w_hit      = i_wr_ok && (i_waddr == i_raddr);
  assign w_merged   = WIDTH'(rf_strb_merge(
                        rf_word_t'(w_old),
                        rf_word_t'(i_wdata),
                        rf_strb_t'(i_wstrb)));
  assign w_next     = w_hit ? w_merged : w_old;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= i_read_en;
      if (i_read_en) r_rdata <= w_next;
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: DEPTH x WIDTH register file, one write, NUM_RD reads.
// Define RF_ZERO_REG_EN to hardwire entry 0 to zero.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH_DEF,
  parameter int WIDTH  = RF_WIDTH_DEF,
  parameter int NUM_RD = RF_NUM_RD_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_RD-1:0]       read_en,
  input  logic [NUM_RD*AW-1:0]    raddr,
  input  logic                    write_en,
  input  logic [AW-1:0]           waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [WIDTH/8-1:0]      wstrb,
  output logic [NUM_RD*WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]       rvalid
);
`ifdef RF_ZERO_REG_EN
  localparam bit LP_ZERO = 1'b1;
`else
  localparam bit LP_ZERO = 1'b0;
`endif
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] w_mem [DEPTH];
  logic             w_wr_zero;
  logic             w_wr_ok;

  assign w_wr_zero = LP_ZERO && (waddr == '0);
  assign w_wr_ok   = write_en
                  && ({1'b0, waddr} < LP_DEPTH)
                  && !w_wr_zero;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    if (LP_ZERO && e == 0) begin : g_zero
      assign w_mem[e] = '0;
    end else begin : g_flop
      logic [WIDTH-1:0] r_ent;
      logic             w_we;

      assign w_we = w_wr_ok && (waddr == AW'(e));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_ent <= '0;
        end else if (w_we) begin
          r_ent <= WIDTH'(rf_strb_merge(
                     rf_word_t'(r_ent),
                     rf_word_t'(wdata),
                     rf_strb_t'(wstrb)));
        end
      end

      assign w_mem[e] = r_ent;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_read_port #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AW    (AW)
    ) u_port (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_read_en (read_en[p]),
      .i_raddr   (raddr[p*AW +: AW]),
      .i_mem     (w_mem),
      .i_wr_ok   (w_wr_ok),
      .i_waddr   (waddr),
      .i_wdata   (wdata),
      .i_wstrb   (wstrb),
      .o_rdata   (rdata[p*WIDTH +: WIDTH]),
      .o_rvalid  (rvalid[p])
    );
  end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed scoreboard bench for register_file_mp.
// Drives a 16x64x2 default instance and a 12x32x3 instance.
`timescale 1ns/1ps
module tb_register_file_mp;
`ifdef RF_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [1:0]   re_a;
  logic [7:0]   ra_a;
  logic         we_a;
  logic [3:0]   wa_a;
  logic [63:0]  wd_a;
  logic [7:0]   ws_a;
  logic [127:0] rd_a;
  logic [1:0]   rv_a;

  logic [2:0]   re_b;
  logic [11:0]  ra_b;
  logic         we_b;
  logic [3:0]   wa_b;
  logic [31:0]  wd_b;
  logic [3:0]   ws_b;
  logic [95:0]  rd_b;
  logic [2:0]   rv_b;

  register_file_mp u_a (
    .clk(clk), .reset_n(reset_n),
    .read_en(re_a), .raddr(ra_a),
    .write_en(we_a), .waddr(wa_a),
    .wdata(wd_a), .wstrb(ws_a),
    .rdata(rd_a), .rvalid(rv_a)
  );

  register_file_mp #(
    .DEPTH(12), .WIDTH(32), .NUM_RD(3)
  ) u_b (
    .clk(clk), .reset_n(reset_n),
    .read_en(re_b), .raddr(ra_b),
    .write_en(we_b), .waddr(wa_b),
    .wdata(wd_b), .wstrb(ws_b),
    .rdata(rd_b), .rvalid(rv_b)
  );

  typedef struct {
    string       tag;
    int          dut;
    int          port;
    logic [63:0] data;
    logic        valid;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] m_a [16];
  logic [31:0] m_b [12];
  logic [63:0] hold_a [2];
  logic [31:0] hold_b [3];
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic logic [63:0] mrg(
    input logic [63:0] o,
    input logic [63:0] n,
    input logic [7:0]  s
  );
    for (int b = 0; b < 8; b++)
      if (s[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) m_a[i] = '0;
    for (int i = 0; i < 12; i++) m_b[i] = '0;
    for (int i = 0; i < 2; i++) hold_a[i] = '0;
    for (int i = 0; i < 3; i++) hold_b[i] = '0;
    sbq.delete();
  endtask

  task automatic idle();
    re_a = '0; ra_a = '0; we_a = 1'b0;
    wa_a = '0; wd_a = '0; ws_a = '0;
    re_b = '0; ra_b = '0; we_b = 1'b0;
    wa_b = '0; wd_b = '0; ws_b = '0;
  endtask

  task automatic tick();
    exp_t        e;
    logic [63:0] obs;
    logic        v;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.dut == 0) begin
        obs = rd_a[e.port*64 +: 64];
        v   = rv_a[e.port];
      end else begin
        obs = {32'b0, rd_b[e.port*32 +: 32]};
        v   = rv_b[e.port];
      end
      check({e.tag, "_data"}, obs, e.data);
      check({e.tag, "_valid"}, {63'b0, v}, {63'b0, e.valid});
    end
  endtask

  task automatic step_a(
    input string       tag,
    input logic        we,
    input logic [3:0]  wa,
    input logic [63:0] wd,
    input logic [7:0]  ws,
    input logic [1:0]  re,
    input logic [3:0]  r0,
    input logic [3:0]  r1
  );
    logic [3:0]  ra [2];
    logic [63:0] v;
    logic        wok;
    exp_t        e;
    ra[0] = r0; ra[1] = r1;
    we_a = we; wa_a = wa; wd_a = wd; ws_a = ws;
    re_a = re; ra_a = {r1, r0};
    wok = we && !(ZR && wa == 4'd0);
    for (int p = 0; p < 2; p++) begin
      if (re[p]) begin
        v = (ZR && ra[p] == 4'd0) ? 64'b0 : m_a[ra[p]];
        if (wok && wa == ra[p]) v = mrg(v, wd, ws);
        hold_a[p] = v;
      end
      e.tag = tag; e.dut = 0; e.port = p;
      e.data = hold_a[p]; e.valid = re[p];
      sbq.push_back(e);
    end
    if (wok) m_a[wa] = mrg(m_a[wa], wd, ws);
    tick();
  endtask

  task automatic step_b(
    input string       tag,
    input logic        we,
    input logic [3:0]  wa,
    input logic [31:0] wd,
    input logic [3:0]  ws,
    input logic [2:0]  re,
    input logic [3:0]  r0,
    input logic [3:0]  r1,
    input logic [3:0]  r2
  );
    logic [3:0]  ra [3];
    logic [63:0] v;
    logic        wok;
    exp_t        e;
    ra[0] = r0; ra[1] = r1; ra[2] = r2;
    we_b = we; wa_b = wa; wd_b = wd; ws_b = ws;
    re_b = re; ra_b = {r2, r1, r0};
    wok = we && wa < 4'd12 && !(ZR && wa == 4'd0);
    for (int p = 0; p < 3; p++) begin
      if (re[p]) begin
        v = 64'b0;
        if (ra[p] < 4'd12 && !(ZR && ra[p] == 4'd0))
          v = {32'b0, m_b[ra[p]]};
        if (wok && wa == ra[p])
          v = mrg(v, {32'b0, wd}, {4'b0, ws});
        hold_b[p] = v[31:0];
      end
      e.tag = tag; e.dut = 1; e.port = p;
      e.data = {32'b0, hold_b[p]}; e.valid = re[p];
      sbq.push_back(e);
    end
    if (wok) begin
      v = mrg({32'b0, m_b[wa]}, {32'b0, wd}, {4'b0, ws});
      m_b[wa] = v[31:0];
    end
    tick();
  endtask

  initial begin
    logic [63:0] w;
    reset_n = 1'b1;
    idle();
    clear_model();
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata_a", rd_a[63:0] | rd_a[127:64], 64'b0);
    check("rst_rvalid_a", {62'b0, rv_a}, 64'b0);
    check("rst_rdata_b", {32'b0, rd_b[31:0] | rd_b[63:32] | rd_b[95:64]}, 64'b0);
    check("rst_rvalid_b", {61'b0, rv_b}, 64'b0);
    reset_n = 1'b1;

    for (int a = 0; a < 16; a += 2)
      step_a("rst_rd_a", 1'b0, 4'd0, 64'b0, 8'h00, 2'b11, 4'(a), 4'(a + 1));
    for (int a = 0; a < 12; a += 3)
      step_b("rst_rd_b", 1'b0, 4'd0, 32'b0, 4'h0, 3'b111, 4'(a), 4'(a + 1), 4'(a + 2));

    for (int r = 0; r < 16; r++) begin
      w = 64'b0;
      for (int n = 0; n < 128; n++) begin
        w = {w[62:0], (n < 64)};
        step_a("walk_wr", 1'b1, 4'(r), w, 8'hFF, 2'b00, 4'd0, 4'd0);
        step_a("walk_p0", 1'b0, 4'd0, 64'b0, 8'h00, 2'b01, 4'(r), 4'd0);
        step_a("walk_p1", 1'b0, 4'd0, 64'b0, 8'h00, 2'b10, 4'd0, 4'(r));
        step_a("walk_pp", 1'b0, 4'd0, 64'b0, 8'h00, 2'b11, 4'(r), 4'(r));
        if (r == 1 && n == 7)
          check("walk_8th", rd_a[63:0], 64'h0000_0000_0000_00FF);
      end
    end

    step_a("strb_ff", 1'b1, 4'd5, '1, 8'hFF, 2'b00, 4'd0, 4'd0);
    step_a("strb_0f", 1'b1, 4'd5, 64'b0, 8'h0F, 2'b00, 4'd0, 4'd0);
    step_a("strb_rd", 1'b0, 4'd0, 64'b0, 8'h00, 2'b11, 4'd5, 4'd5);
    check("strb_word", rd_a[127:64], 64'hFFFF_FFFF_0000_0000);
    step_a("strb_nop", 1'b1, 4'd5, 64'b0, 8'h00, 2'b01, 4'd5, 4'd0);

    step_a("byp_clr", 1'b1, 4'd3, 64'b0, 8'hFF, 2'b00, 4'd0, 4'd0);
    step_a("byp_ff", 1'b1, 4'd3, 64'hDEAD_BEEF_0123_4567, 8'hFF, 2'b11, 4'd3, 4'd3);
    check("byp_p0", rd_a[63:0], 64'hDEAD_BEEF_0123_4567);
    check("byp_p1", rd_a[127:64], 64'hDEAD_BEEF_0123_4567);
    step_a("byp_clr2", 1'b1, 4'd3, 64'b0, 8'hFF, 2'b00, 4'd0, 4'd0);
    step_a("byp_f0", 1'b1, 4'd3, 64'hDEAD_BEEF_0123_4567, 8'hF0, 2'b11, 4'd3, 4'd3);
    check("byp_f0_p1", rd_a[127:64], 64'hDEAD_BEEF_0000_0000);
    step_a("byp_after", 1'b0, 4'd0, 64'b0, 8'h00, 2'b11, 4'd3, 4'd5);

`ifdef RF_ZERO_REG_EN
    step_a("zr_wr", 1'b1, 4'd0, 64'h1234, 8'hFF, 2'b11, 4'd0, 4'd0);
    step_a("zr_rd", 1'b0, 4'd0, 64'b0, 8'h00, 2'b11, 4'd0, 4'd0);
    check("zr_word", rd_a[63:0], 64'b0);
`endif

    step_b("b_range", 1'b1, 4'd2, 32'hA5A5_A5A5, 4'hF, 3'b111, 4'd13, 4'd2, 4'd11);
    check("b_oor_data", {32'b0, rd_b[31:0]}, 64'b0);
    check("b_oor_valid", {63'b0, rv_b[0]}, 64'd1);
    step_b("b_strb", 1'b1, 4'd7, 32'h1234_5678, 4'h3, 3'b100, 4'd0, 4'd0, 4'd7);
    step_b("b_wr14", 1'b1, 4'd14, 32'hFFFF_FFFF, 4'hF, 3'b000, 4'd0, 4'd0, 4'd0);
    for (int a = 0; a < 12; a += 3)
      step_b("b_scan", 1'b0, 4'd0, 32'b0, 4'h0, 3'b111, 4'(a), 4'(a + 1), 4'(a + 2));
    step_b("b_15", 1'b0, 4'd0, 32'b0, 4'h0, 3'b100, 4'd0, 4'd0, 4'd15);
    step_b("b_hold", 1'b1, 4'd7, 32'hCAFE_0000, 4'hF, 3'b000, 4'd7, 4'd7, 4'd7);
    step_b("b_hold2", 1'b0, 4'd0, 32'b0, 4'h0, 3'b010, 4'd7, 4'd7, 4'd7);

    step_a("pre_rst", 1'b1, 4'd9, 64'h55, 8'hFF, 2'b11, 4'd5, 4'd3);
    re_a = 2'b11; ra_a = 8'h95;
    #3 reset_n = 1'b0;
    #1;
    check("mid_rst_rdata_a", rd_a[63:0] | rd_a[127:64], 64'b0);
    check("mid_rst_rvalid_a", {62'b0, rv_a}, 64'b0);
    check("mid_rst_rvalid_b", {61'b0, rv_b}, 64'b0);
    clear_model();
    idle();
    @(posedge clk);
    #1 reset_n = 1'b1;
    step_a("post_rst", 1'b0, 4'd0, 64'b0, 8'h00, 2'b11, 4'd5, 4'd9);
    step_b("post_rst_b", 1'b0, 4'd0, 32'b0, 4'h0, 3'b111, 4'd2, 4'd7, 4'd11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file. It generalises the 16 x 64, two-read/one-write register file to a configurable depth, width and read-port count. It adds registered reads with write-first bypass, byte-strobed writes and per-port read-valid flags. It sits in the core datapath between decode (operand reads) and writeback (single write port).

## Interface
- `DEPTH`, default 16: number of registers, ≥2, not required to be a power of two.
- `WIDTH`, default 64: register width in bits, a multiple of 8.
- `NUM_RD`, default 2: number of read ports, 1..4.
- `AW`, default `$clog2(DEPTH)`: address width, derived; do not override.

Ports:
- `clk`  in  1  the single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `read_en`  in  NUM_RD  per-port read request, bit p for port p.
- `raddr`  in  NUM_RD*AW  packed read addresses; port p is `[p*AW +: AW]`.
- `write_en`  in  1  write request.
- `waddr`  in  AW  write address.
- `wdata`  in  WIDTH  write data.
- `wstrb`  in  WIDTH/8  byte write enables; bit b covers `wdata[8b+7:8b]`.
- `rdata`  out  NUM_RD*WIDTH  packed read data; port p is `[p*WIDTH +: WIDTH]`.
- `rvalid`  out  NUM_RD  port p returned data this cycle.

## Operation
- **Storage:** DEPTH x WIDTH flops. Reset clears every entry to 0.
- **Write:** at a posedge with `write_en`=1 and `waddr`<DEPTH, each byte with `wstrb[b]`=1 is updated.
  - Bytes with `wstrb[b]`=0 keep their value.
  - `wstrb`=0 is a legal no-op.
  - `waddr`≥DEPTH: the write is dropped silently.
- **Read:** at a posedge with `read_en[p]`=1, port p registers the entry at `raddr[p]` into its `rdata` slice and sets `rvalid[p]`=1 for one cycle.
  - `read_en[p]`=0: the `rdata` slice holds its previous value and `rvalid[p]`=0.
- **Bypass (write-first):** if a read and a write hit the same in-range address in the same cycle, the read returns the merged value: new bytes where `wstrb`=1, old bytes elsewhere. This applies to every port independently.
- **Out-of-range read** (`raddr[p]`≥DEPTH): `rdata` slice is 0 and `rvalid[p]`=1.
- Multiple ports may read the same address in the same cycle; all return identical data.

## Timing
- **Write latency:** 1 cycle. Data written at posedge k is visible to reads sampled at posedge k+1. Through the bypass it is also visible to reads sampled at posedge k.
- **Read latency:** 1 cycle. Inputs are sampled at posedge k; `rdata`/`rvalid` change just after posedge k and are stable through cycle k+1.
- **Throughput:** one write plus NUM_RD reads every cycle, with no stalls and no backpressure.
- **Reset values:** `rdata`=0 and `rvalid`=0 on all ports; all entries 0.
- **Reset mid-operation:** asserting `reset_n`=0 at any time clears storage and outputs immediately, without waiting for a clock edge.
  - A write coincident with the deasserting edge is ignored if `reset_n` is still low at that posedge.
  - The first write or read is honoured at the first posedge after `reset_n` goes high.

## Configuration
- Macro `RF_ZERO_REG_EN`.
- **Defined:** entry 0 is hardwired to zero.
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 with `rvalid`=1.
  - Bypass never forwards to address 0.
  - No flops are built for entry 0.
- **Undefined:** entry 0 is an ordinary register.

## Structure
- **Package `rf_pkg`:**
  - `RF_DEPTH_DEF`, `RF_WIDTH_DEF`, `RF_NUM_RD_DEF` constants.
  - A `rf_strb_merge` function taking old data, new data and strobes, returning the merged word. The storage write and the bypass use the same function.
- **Sub-module `rf_read_port`:** instantiated NUM_RD times with a generate loop. It contains the address mux, the same-address compare, the bypass merge, and the `rdata`/`rvalid` output registers for one port.
- **Top level:** storage array, write decode, range checks, port packing/unpacking.

## Test plan
- **Reset values:** hold `reset_n`=0 for 2 cycles → all `rdata`=0, `rvalid`=0. Read each address after release → 0.
- **Walking ones/zeros:** default params. For each of the 16 registers, shift in 1s then 0s over 128 writes with `wstrb`=all-ones. After each write, read on port 0, then port 1, then both → each returns the shifted word, e.g. `64'h0000_0000_0000_00FF` after 8 writes.
- **Strobes:** write `64'hFFFF_FFFF_FFFF_FFFF` to reg 5, then `64'h0` with `wstrb`=`8'h0F` → read returns `64'hFFFF_FFFF_0000_0000`.
- **Bypass:** in the same cycle, write `64'hDEAD_BEEF_0123_4567` to reg 3 with port 0 and port 1 both reading reg 3 (old value `64'h0`) → next cycle both return `64'hDEAD_BEEF_0123_4567`. Repeat with `wstrb`=`8'hF0` → `64'hDEAD_BEEF_0000_0000`.
- **Hold and range:** DEPTH=12, WIDTH=32, NUM_RD=3.
  - Read addr 13 → 0 with `rvalid`=1.
  - Write to addr 14 → no entry changes.
  - Deassert `read_en` → `rdata` unchanged and `rvalid`=0.
- **Zero register** (`RF_ZERO_REG_EN` defined): write `64'h1234` to reg 0, read it → 0. Assert `reset_n`=0 mid-burst → outputs 0 before the next edge.
